prog_mem_dp: RTL

PROG_MEM_DP -- requirements
Module: prog_mem_dp

---
 rtl/prog_mem_if.sv | 31 +++
 rtl/prog_mem_dp.sv | 127 ++++++++++++
 2 files changed

// File: rtl/prog_mem_if.sv
// Fetch/load/control bundle for the dual-port program memory.
// The master drives requests; the slave (memory) returns fetch data, acks and status.
`timescale 1ns/1ps
interface prog_mem_if #(
    parameter int DATA_SIZE = 16,
    parameter int ADDR_SIZE = 4
);
    logic                 clr;
    logic                 init_busy;
    logic                 f_req;
    logic [ADDR_SIZE-1:0] f_addr;
    logic                 f_ready;
    logic                 f_valid;
    logic [DATA_SIZE-1:0] f_data;
    logic                 f_perr;
    logic                 l_we;
    logic [ADDR_SIZE-1:0] l_addr;
    logic [DATA_SIZE-1:0] l_data;
    logic                 l_perr_inj;
    logic                 l_ack;

    modport master (
        output clr, f_req, f_addr, l_we, l_addr, l_data, l_perr_inj,
        input  init_busy, f_ready, f_valid, f_data, f_perr, l_ack
    );

    modport slave (
        input  clr, f_req, f_addr, l_we, l_addr, l_data, l_perr_inj,
        output init_busy, f_ready, f_valid, f_data, f_perr, l_ack
    );
endinterface

// File: rtl/prog_mem_dp.sv
// Program memory: one fetch port, one load port, self-clearing sweep after reset/clr.
// Optional per-word even parity is enabled by defining PROG_MEM_PARITY_EN.
`timescale 1ns/1ps
module prog_mem_dp #(
    parameter int                   DATA_SIZE  = 16,
    parameter int                   ADDR_SIZE  = 4,
    parameter logic [DATA_SIZE-1:0] FILL_VALUE = '0
) (
    input  logic      clk,
    input  logic      rstn,
    prog_mem_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_SIZE;
`ifdef PROG_MEM_PARITY_EN
    localparam int WORD_W = DATA_SIZE + 1;
`else
    localparam int WORD_W = DATA_SIZE;
`endif

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    function automatic logic even_par(input logic [DATA_SIZE-1:0] d);
        return ^d;
    endfunction

    function automatic logic [WORD_W-1:0] encode(input logic [DATA_SIZE-1:0] d,
                                                 input logic inj);
`ifdef PROG_MEM_PARITY_EN
        return {even_par(d) ^ inj, d};
`else
        return (inj & 1'b0) ? '0 : d;
`endif
    endfunction

    logic [0:0]           state;
    logic [ADDR_SIZE-1:0] ptr;
    logic                 busy;
    logic                 f_acc;
    logic                 l_acc;
    logic                 mem_we;
    logic [ADDR_SIZE-1:0] mem_wa;
    logic [WORD_W-1:0]    mem_wd;
    logic [WORD_W-1:0]    rd_word;
    logic [WORD_W-1:0]    mem [DEPTH];

    assign busy          = (state == ST_INIT);
    assign bus.init_busy = busy;
    assign bus.f_ready   = !busy;
    assign f_acc         = bus.f_req && !busy;
    assign l_acc         = bus.l_we && !busy;

    // Sweep controller: one fill write per cycle, clr restarts from address 0
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_INIT;
            ptr   <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (bus.clr) begin
                        ptr <= '0;
                    end else begin
                        ptr <= ptr + ADDR_SIZE'(1);
                        if (ptr == '1) state <= ST_READY;
                    end
                end
                ST_READY: begin
                    if (bus.clr) begin
                        state <= ST_INIT;
                        ptr   <= '0;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    // Single write port shared by the sweep and the load port (never both active)
    assign mem_we = busy || l_acc;
    assign mem_wa = busy ? ptr : bus.l_addr;
    assign mem_wd = busy ? encode(FILL_VALUE, 1'b0) : encode(bus.l_data, bus.l_perr_inj);

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    // Write-first: a same-address load in the fetch cycle is forwarded
    assign rd_word = (l_acc && (bus.l_addr == bus.f_addr)) ? mem_wd : mem[bus.f_addr];

    // Stage p1: registered fetch result and load acknowledge
    logic                 f_vld_p1;
    logic [DATA_SIZE-1:0] f_data_p1;
    logic                 l_ack_p1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            f_vld_p1  <= 1'b0;
            f_data_p1 <= '0;
            l_ack_p1  <= 1'b0;
        end else begin
            f_vld_p1 <= f_acc;
            l_ack_p1 <= l_acc;
            if (f_acc) f_data_p1 <= rd_word[DATA_SIZE-1:0];
        end
    end

    assign bus.f_valid = f_vld_p1;
    assign bus.f_data  = f_data_p1;
    assign bus.l_ack   = l_ack_p1;

`ifdef PROG_MEM_PARITY_EN
    logic f_perr_p1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            f_perr_p1 <= 1'b0;
        end else if (f_acc) begin
            f_perr_p1 <= even_par(rd_word[DATA_SIZE-1:0]) ^ rd_word[DATA_SIZE];
        end
    end

    assign bus.f_perr = f_perr_p1;
`else
    assign bus.f_perr = 1'b0;
`endif
endmodule
